// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - state encoding and sizing constants shared by the data-memory responder
package dmem_pkg;

  localparam int DMEM_AW_DEF = 5;
  localparam int DMEM_DW_DEF = 32;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Counter preload on accept: WAIT runs cnt+1 cycles, so load LATENCY-1.
  function automatic logic [CNT_W-1:0] wait_count(input int lat);
    return (lat == 0) ? '0 : CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with byte-masked synchronous write and registered synchronous read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int AW = DMEM_AW_DEF,
  parameter int DW = DMEM_DW_DEF,
  localparam int NB = DW / 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [NB-1:0] wr_be_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_data_q;

  // Storage is deliberately outside reset so contents survive a pipeline flush.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be_i[b]) begin
          mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data-memory responder with fixed access latency; DMEM_BYTE_EN adds store byte enables
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int AW      = DMEM_AW_DEF,
  parameter int DW      = DMEM_DW_DEF,
  parameter int LATENCY = 2
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
`ifdef DMEM_BYTE_EN
  input  logic [DW/8-1:0] be,
`endif
  output logic          ready,
  output logic          rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_stall
);

  localparam int NB = DW / 8;

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [NB-1:0]    be_q, be_d, be_in;

  logic             commit;
  logic             op_we;
  logic [AW-1:0]    op_addr;
  logic [DW-1:0]    op_wdata;
  logic [NB-1:0]    op_be;
  logic             wr_en, rd_en;

`ifdef DMEM_BYTE_EN
  assign be_in = be;
`else
  assign be_in = '1;
`endif

  // commit marks the edge that enters RESP; with zero latency that is the accept edge,
  // so the operation comes straight from the inputs instead of the latches.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    commit   = 1'b0;
    op_we    = we_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    op_be    = be_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be_in;
          if (LATENCY == 0) begin
            state_d  = RESP;
            commit   = 1'b1;
            op_we    = we;
            op_addr  = addr;
            op_wdata = wdata;
            op_be    = be_in;
          end else begin
            state_d = WAIT;
            cnt_d   = wait_count(LATENCY);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // Reset on the entering edge aborts the access, so neither port may fire.
  assign wr_en = commit & op_we & ~Reset;
  assign rd_en = commit & ~op_we & ~Reset;

  dmem_array #(
    .AW (AW),
    .DW (DW)
  ) u_array (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .wr_en_i   (wr_en),
    .wr_addr_i (op_addr),
    .wr_data_i (op_wdata),
    .wr_be_i   (op_be),
    .rd_en_i   (rd_en),
    .rd_addr_i (op_addr),
    .rd_data_o (rdata)
  );

  assign ready     = (state_q == IDLE);
  assign rvalid    = (state_q == RESP);
  assign mem_stall = req && (state_q != RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - bench for dmem_responder (LATENCY 2 and 0 instances); honours DMEM_BYTE_EN
module tb_dmem_responder;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NB    = 4;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [2];
  logic          req       [2];
  logic          we        [2];
  logic [AW-1:0] addr      [2];
  logic [DW-1:0] wdata     [2];
  logic [NB-1:0] be        [2];
  logic          ready     [2];
  logic          rvalid    [2];
  logic          mem_stall [2];
  logic [DW-1:0] rdata     [2];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.AW(AW), .DW(DW), .LATENCY(2)) u_dut_l2 (
    .Clock     (clk),
    .Reset     (rst[0]),
    .req       (req[0]),
    .we        (we[0]),
    .addr      (addr[0]),
    .wdata     (wdata[0]),
`ifdef DMEM_BYTE_EN
    .be        (be[0]),
`endif
    .ready     (ready[0]),
    .rvalid    (rvalid[0]),
    .rdata     (rdata[0]),
    .mem_stall (mem_stall[0])
  );

  dmem_responder #(.AW(AW), .DW(DW), .LATENCY(0)) u_dut_l0 (
    .Clock     (clk),
    .Reset     (rst[1]),
    .req       (req[1]),
    .we        (we[1]),
    .addr      (addr[1]),
    .wdata     (wdata[1]),
`ifdef DMEM_BYTE_EN
    .be        (be[1]),
`endif
    .ready     (ready[1]),
    .rvalid    (rvalid[1]),
    .rdata     (rdata[1]),
    .mem_stall (mem_stall[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [NB-1:0] mask);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < NB; b++) if (mask[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Transaction-level model: an accepted op completes at cycle accept+LATENCY+1,
  // and its memory effect lands on the edge just before that cycle.
  bit            live     [2];
  bit            m_busy   [2];
  int            m_resp   [2];
  bit            m_we     [2];
  logic [AW-1:0] m_addr   [2];
  logic [DW-1:0] m_wdata  [2];
  logic [NB-1:0] m_be     [2];
  logic [DW-1:0] m_rdata  [2];
  bit            m_rknown [2];
  logic [DW-1:0] m_mem    [2][DEPTH];
  bit            m_known  [2][DEPTH];
  int            cyc = 0;
  bit            exp_rv;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (live[k]) begin
        exp_rv = m_busy[k] && (cyc == m_resp[k]);
        check($sformatf("ready[%0d]@%0d", k, cyc), ready[k], !m_busy[k]);
        check($sformatf("rvalid[%0d]@%0d", k, cyc), rvalid[k], exp_rv);
        check($sformatf("mem_stall[%0d]@%0d", k, cyc), mem_stall[k], req[k] && !exp_rv);
        if (m_rknown[k]) check($sformatf("rdata[%0d]@%0d", k, cyc), rdata[k], m_rdata[k]);
      end
      if (rst[k]) begin
        live[k]     = 1'b1;
        m_busy[k]   = 1'b0;
        m_rdata[k]  = '0;
        m_rknown[k] = 1'b1;
      end else if (live[k]) begin
        if (m_busy[k] && cyc == m_resp[k]) begin
          m_busy[k] = 1'b0;
        end else if (!m_busy[k] && req[k]) begin
          m_busy[k]  = 1'b1;
          m_resp[k]  = cyc + lat_of(k) + 1;
          m_we[k]    = we[k];
          m_addr[k]  = addr[k];
          m_wdata[k] = wdata[k];
`ifdef DMEM_BYTE_EN
          m_be[k]    = be[k];
`else
          m_be[k]    = '1;
`endif
        end
        if (m_busy[k] && m_resp[k] == cyc + 1) begin
          if (m_we[k]) begin
            m_mem[k][m_addr[k]]   = merge(m_mem[k][m_addr[k]], m_wdata[k], m_be[k]);
            m_known[k][m_addr[k]] = m_known[k][m_addr[k]] || (m_be[k] == '1);
          end else begin
            m_rdata[k]  = m_mem[k][m_addr[k]];
            m_rknown[k] = m_known[k][m_addr[k]];
          end
        end
      end
    end
    cyc++;
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the RESP edge.
  task automatic run_op(input int k, input bit w, input int a, input logic [DW-1:0] d,
                        input logic [NB-1:0] m, output logic [DW-1:0] rd, output int rv_at,
                        output int stalls, output logic stall_at_rv);
    rv_at = -1;
    stalls = 0;
    rd = '0;
    stall_at_rv = 1'b1;
    req[k] = 1'b1;
    we[k] = w;
    addr[k] = AW'(a);
    wdata[k] = d;
    be[k] = m;
    for (int t = 0; t < 20 && rv_at < 0; t++) begin
      @(negedge clk);
      if (rvalid[k]) begin
        rv_at = t;
        rd = rdata[k];
        stall_at_rv = mem_stall[k];
      end else if (mem_stall[k]) begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    req[k] = 1'b0;
  endtask

  task automatic do_op(input int k, input bit w, input int a, input logic [DW-1:0] d,
                       input logic [NB-1:0] m, input string nm, output logic [DW-1:0] rd);
    int rv_at, stalls;
    logic sr;
    run_op(k, w, a, d, m, rd, rv_at, stalls, sr);
    check({nm, " rvalid cycle"}, rv_at, lat_of(k) + 1);
    check({nm, " stall cycles"}, stalls, lat_of(k) + 1);
    check({nm, " stall at rvalid"}, sr, 1'b0);
  endtask

  function automatic logic [DW-1:0] pre_val(input int k, input int a);
    if (k == 0 && a == 2) return 32'hAABBCCDD;
    if (k == 0 && a == 3) return 32'h33330003;
    if (k == 0 && a == 7) return 32'h00000000;
    if (k == 0 && a == 9) return 32'h99990009;
    if (k == 1 && a == 31) return 32'h12345678;
    return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    int got, rv_seen;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req[k] = 1'b1; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0; be[k] = '1;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset ready[%0d]", k), ready[k], 1'b1);
      check($sformatf("reset rvalid[%0d]", k), rvalid[k], 1'b0);
      check($sformatf("reset rdata[%0d]", k), rdata[k], '0);
    end
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    req[1] = 1'b0;
    @(negedge clk);
    check("first op accepted L2", ready[0], 1'b0);
    check("first op rvalid L0", rvalid[1], 1'b1);
    check("stall low on req drop", mem_stall[0], 1'b0);
    repeat (5) @(posedge clk);
    #1;

    for (int k = 0; k < 2; k++)
      for (int a = 0; a < DEPTH; a++)
        do_op(k, 1'b1, a, pre_val(k, a), '1, $sformatf("preload[%0d]", k), rd);

    do_op(0, 1'b1, 5, 32'hDEADBEEF, '1, "store5", rd);
    do_op(0, 1'b0, 5, 32'h0, '1, "load5", rd);
    check("load5 data", rd, 32'hDEADBEEF);

    do_op(1, 1'b0, 31, 32'h0, '1, "L0 load31", rd);
    check("L0 load31 data", rd, 32'h12345678);

    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 5'd3;
    @(posedge clk);
    #1;
    addr[0] = 5'd9; req[0] = 1'b0; we[0] = 1'b1; wdata[0] = 32'h55555555;
    got = 0;
    rd = '0;
    for (int t = 0; t < 10 && got == 0; t++) begin
      @(negedge clk);
      if (t == 0) begin
        check("wait stall with req low", mem_stall[0], 1'b0);
        check("wait ready", ready[0], 1'b0);
      end
      if (rvalid[0]) begin
        got = 1;
        rd = rdata[0];
      end
      @(posedge clk);
      #1;
    end
    check("addr change rvalid seen", got, 1);
    check("addr change data", rd, 32'h33330003);
    @(negedge clk);
    check("ready after resp", ready[0], 1'b1);
    @(posedge clk);
    #1;

    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 5'd7; wdata[0] = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rv_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid[0]) rv_seen++;
      @(posedge clk);
      #1;
    end
    check("no rvalid after abort", rv_seen, 0);
    do_op(0, 1'b0, 7, 32'h0, '1, "load7", rd);
    check("aborted store", rd, 32'h00000000);

`ifdef DMEM_BYTE_EN
    do_op(0, 1'b1, 2, 32'h11223344, 4'b0101, "be store", rd);
    do_op(0, 1'b0, 2, 32'h0, 4'b0000, "be load", rd);
    check("be merge", rd, 32'hAA22CC44);
    do_op(0, 1'b1, 2, 32'hFFFFFFFF, 4'b0000, "be0 store", rd);
    do_op(0, 1'b0, 2, 32'h0, 4'b1111, "be0 load", rd);
    check("be0 no-op", rd, 32'hAA22CC44);
`endif

    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        rst[k]   = ($urandom_range(0, 79) == 0);
        req[k]   = ($urandom_range(0, 3) != 0);
        we[k]    = $urandom_range(0, 1) != 0;
        addr[k]  = AW'($urandom);
        wdata[k] = $urandom;
        be[k]    = NB'($urandom);
      end
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0;
      req[k] = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
